// File: rtl/reaction_pkg.sv
// Shared types and constants for the multi-player reaction timer.
package reaction_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      GO    = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } state_t;

   // {r,g,b} colour codes for the RGB PWM
   localparam logic [2:0] COL_BLUE    = 3'b001;
   localparam logic [2:0] COL_RED     = 3'b100;
   localparam logic [2:0] COL_GREEN   = 3'b010;
   localparam logic [2:0] COL_WHITE   = 3'b111;
   localparam logic [2:0] COL_MAGENTA = 3'b101;

   // Right-shifting Galois LFSR taps for x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [2:0] state_colour(input state_t s);
      case (s)
         IDLE:    return COL_BLUE;
         ARMED:   return COL_RED;
         GO:      return COL_GREEN;
         DONE:    return COL_WHITE;
         FAULT:   return COL_MAGENTA;
         default: return COL_BLUE;
      endcase
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear and saturation at all-9s.
module bcd_counter #(
   parameter int NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 RESET,
   input  logic                 clr,
   input  logic                 inc,
   output logic [NDIGITS*4-1:0] q,
   output logic                 at_max
);

   localparam logic [NDIGITS*4-1:0] ALL_NINES = {NDIGITS{4'h9}};

   logic [NDIGITS*4-1:0] cnt_q, cnt_d;
   logic                 carry;

   assign at_max = (cnt_q == ALL_NINES);
   assign q      = cnt_q;

   // Next count: clear wins, otherwise ripple a decimal carry up from digit 0
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      cnt_d = cnt_q;
      carry = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !at_max) begin
         carry = 1'b1;
         for (int i = 0; i < NDIGITS; i++) begin
            if (carry) begin
               if (cnt_q[i*4 +: 4] == 4'd9) begin
                  cnt_d[i*4 +: 4] = 4'd0;
               end else begin
                  cnt_d[i*4 +: 4] = cnt_q[i*4 +: 4] + 4'd1;
                  carry           = 1'b0;
               end
            end
         end
      end
   end

   // Count register
   always_ff @(posedge clk or negedge RESET) begin
      // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
      if (!RESET) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random arm delay, ms BCD race, winner and best times.
module reaction_timer_mp
   import reaction_pkg::*;
#(
   parameter int          NPLAYERS    = 2,
   parameter int          NDIGITS     = 4,
   parameter int          TICK_DIV    = 100000,
   parameter int          MIN_WAIT_MS = 1000,
   parameter int          WAIT_BITS   = 11,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                                               clk,
   input  logic                                               RESET,
   input  logic                                               start,
   input  logic [NPLAYERS-1:0]                                enter,
   input  logic                                               clear_best,
   output logic [2:0]                                         state,
   output logic [2:0]                                         color,
   output logic [NDIGITS*4-1:0]                               live_bcd,
   output logic [NPLAYERS*NDIGITS*4-1:0]                      p_time,
   output logic [NPLAYERS*NDIGITS*4-1:0]                      p_best,
   output logic [NPLAYERS-1:0]                                done_mask,
   output logic [NPLAYERS-1:0]                                false_start,
   output logic [NPLAYERS-1:0]                                late,
   output logic [((NPLAYERS > 1) ? $clog2(NPLAYERS) : 1)-1:0] winner,
   output logic                                               winner_valid,
   output logic                                               tie
);

   localparam int TW       = NDIGITS * 4;
   localparam int WW       = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
   localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DELAY_W  = $clog2(MIN_WAIT_MS + (1 << WAIT_BITS)) + 1;
   localparam logic [TW-1:0] ALL_NINES = {NDIGITS{4'h9}};

   state_t                state_q, state_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic [PRESC_W-1:0]    presc_q, presc_d;
   logic [DELAY_W-1:0]    delay_q, delay_d;
   logic                  start_prev_q;
   logic [NPLAYERS-1:0]   enter_prev_q;
   logic [NPLAYERS-1:0]   done_q, done_d;
   logic [NPLAYERS-1:0]   fs_q, fs_d;
   logic [NPLAYERS-1:0]   late_q, late_d;
   logic [WW-1:0]         winner_q, winner_d;
   logic                  winner_valid_q, winner_valid_d;
   logic                  tie_q, tie_d;

   logic                  start_rise;
   logic [NPLAYERS-1:0]   enter_rise;
   logic                  tick;
   logic [DELAY_W-1:0]    arm_delay;
   logic [NPLAYERS-1:0]   latch_v;
   logic [NPLAYERS-1:0]   late_set;
   logic                  clr_times;
   logic                  live_clr;
   logic                  live_inc;
   logic                  live_at_max;
   logic                  best_upd;

   assign start_rise = start & ~start_prev_q;
   assign enter_rise = enter & ~enter_prev_q;
   assign tick       = (presc_q == PRESC_W'(TICK_DIV - 1));
   assign arm_delay  = DELAY_W'(MIN_WAIT_MS) + DELAY_W'(lfsr_q[WAIT_BITS-1:0]);
   assign best_upd   = (state_d == DONE) && (state_q != DONE);

   bcd_counter #(.NDIGITS(NDIGITS)) u_live (
      .clk    (clk),
      .RESET  (RESET),
      .clr    (live_clr),
      .inc    (live_inc),
      .q      (live_bcd),
      .at_max (live_at_max)
   );

   // LFSR free-runs; prescaler restarts when a round is armed
   always_comb begin
      lfsr_d  = lfsr_next(lfsr_q);
      presc_d = (clr_times || tick) ? '0 : presc_q + PRESC_W'(1);
   end

   // Round FSM: arm delay, false starts, latching, winner and timeout
   always_comb begin
      state_d        = state_q;
      delay_d        = delay_q;
      done_d         = done_q;
      fs_d           = fs_q;
      late_d         = late_q;
      winner_d       = winner_q;
      winner_valid_d = winner_valid_q;
      tie_d          = tie_q;
      latch_v        = '0;
      late_set       = '0;
      clr_times      = 1'b0;
      live_clr       = 1'b0;
      live_inc       = 1'b0;
      case (state_q)
         IDLE, DONE, FAULT: begin
            if (start_rise) begin
               state_d        = ARMED;
               delay_d        = arm_delay;
               done_d         = '0;
               fs_d           = '0;
               late_d         = '0;
               winner_valid_d = 1'b0;
               tie_d          = 1'b0;
               clr_times      = 1'b1;
            end
         end
         ARMED: begin
            fs_d = fs_q | enter_rise;
            if (&fs_d) begin
               state_d = FAULT;
            end else if (tick) begin
               if (delay_q <= DELAY_W'(1)) begin
                  delay_d  = '0;
                  state_d  = GO;
                  live_clr = 1'b1;
               end else begin
                  delay_d = delay_q - DELAY_W'(1);
               end
            end
         end
         GO: begin
            live_inc = tick;
            latch_v  = enter_rise & ~fs_q & ~done_q;
            done_d   = done_q | latch_v;
            if (!winner_valid_q && (|latch_v)) begin
               winner_valid_d = 1'b1;
               tie_d          = ($countones(latch_v) > 1);
               // Walk downwards so the lowest pressed index is left standing
               for (int i = NPLAYERS - 1; i >= 0; i--) begin
                  if (latch_v[i]) winner_d = WW'(i);
               end
            end
            if (live_at_max) begin
               late_set = ~fs_q & ~done_d;
               late_d   = late_q | late_set;
               state_d  = DONE;
            end else if (&(done_d | fs_q)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and status registers
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q        <= IDLE;
         lfsr_q         <= LFSR_SEED;
         presc_q        <= '0;
         delay_q        <= '0;
         start_prev_q   <= 1'b0;
         enter_prev_q   <= '0;
         done_q         <= '0;
         fs_q           <= '0;
         late_q         <= '0;
         winner_q       <= '0;
         winner_valid_q <= 1'b0;
         tie_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         presc_q        <= presc_d;
         delay_q        <= delay_d;
         start_prev_q   <= start;
         enter_prev_q   <= enter;
         done_q         <= done_d;
         fs_q           <= fs_d;
         late_q         <= late_d;
         winner_q       <= winner_d;
         winner_valid_q <= winner_valid_d;
         tie_q          <= tie_d;
      end
   end

   // Per-player time latch and best-time keeper
   for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
      logic [TW-1:0] time_q, time_d;
      logic [TW-1:0] best_q, best_d;

      // Latch race time or the timeout value; fold into best on DONE entry
      always_comb begin
         time_d = time_q;
         best_d = best_q;
         if (clr_times)        time_d = '0;
         else if (latch_v[p])  time_d = live_bcd;
         else if (late_set[p]) time_d = ALL_NINES;
         // Packed BCD compares correctly as plain binary
         if (clear_best) begin
            best_d = ALL_NINES;
         end else if (best_upd && done_d[p] && !late_d[p] && (time_d < best_q)) begin
            best_d = time_d;
         end
      end

      // Player time and best registers
      always_ff @(posedge clk or negedge RESET) begin
         // NOTE: best times are individual flops, so they take the async reset like any other state.
         if (!RESET) begin
            time_q <= '0;
            best_q <= ALL_NINES;
         end else begin
            time_q <= time_d;
            best_q <= best_d;
         end
      end

      assign p_time[p*TW +: TW] = time_q;
      assign p_best[p*TW +: TW] = best_q;
   end

   assign state        = state_q;
   assign color        = state_colour(state_q);
   assign done_mask    = done_q;
   assign false_start  = fs_q;
   assign late         = late_q;
   assign winner       = winner_q;
   assign winner_valid = winner_valid_q;
   assign tie          = tie_q;

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Randomised self-checking bench for reaction_timer_mp against a cycle-count race model.
module tb_reaction_timer_mp;
   import reaction_pkg::*;

   localparam int TICK  = 4;
   localparam int SAT_C = 99 * TICK;   // first GO cycle that reads 99 with two digits

   logic        clk         = 1'b0;
   logic        RESET       = 1'b1;
   logic        start       = 1'b0;
   logic        clear_best  = 1'b0;
   logic [1:0]  enter       = 2'b00;
   logic        start2      = 1'b0;
   logic        clear_best2 = 1'b0;
   logic [1:0]  enter2      = 2'b00;

   logic [2:0]  st, color;
   logic [15:0] live;
   logic [31:0] p_time, p_best;
   logic [1:0]  done_mask, false_start, late;
   logic        winner, winner_valid, tie;

   logic [2:0]  st2, color2;
   logic [7:0]  live2;
   logic [15:0] p_time2, p_best2;
   logic [1:0]  done2, fs2, late2;
   logic        winner2, wv2, tie2;

   int checks = 0;
   int errors = 0;
   int best_ms [2];

   reaction_timer_mp #(
      .NPLAYERS(2), .NDIGITS(4), .TICK_DIV(TICK), .MIN_WAIT_MS(3), .WAIT_BITS(2), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .RESET(RESET), .start(start), .enter(enter), .clear_best(clear_best),
      .state(st), .color(color), .live_bcd(live), .p_time(p_time), .p_best(p_best),
      .done_mask(done_mask), .false_start(false_start), .late(late),
      .winner(winner), .winner_valid(winner_valid), .tie(tie)
   );

   reaction_timer_mp #(
      .NPLAYERS(2), .NDIGITS(2), .TICK_DIV(TICK), .MIN_WAIT_MS(3), .WAIT_BITS(2), .LFSR_SEED(16'hACE1)
   ) dut2 (
      .clk(clk), .RESET(RESET), .start(start2), .enter(enter2), .clear_best(clear_best2),
      .state(st2), .color(color2), .live_bcd(live2), .p_time(p_time2), .p_best(p_best2),
      .done_mask(done2), .false_start(fs2), .late(late2),
      .winner(winner2), .winner_valid(wv2), .tie(tie2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd4(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      x = v;
      for (int d = 0; d < 4; d++) begin
         r[d*4 +: 4] = 4'(x % 10);
         x           = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] best_exp();
      return {to_bcd4(best_ms[1]), to_bcd4(best_ms[0])};
   endfunction

   // All tasks enter and leave on a falling edge
   task automatic start_round();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("armed_state", st, ARMED);
      check("armed_color", color, COL_RED);
      check("armed_ptime", p_time, 32'h0);
   endtask

   task automatic wait_go(output bit ok);
      for (int i = 0; i < 200 && st != GO; i++) @(negedge clk);
      check("go_entry", st, GO);
      ok = (st == GO);
      if (ok) check("go_live0", live, 16'h0);
   endtask

   // Race model: a press during GO cycle c (c=0 is the first GO cycle) latches c/TICK ms.
   // A negative cycle means that player does not press during GO.
   task automatic race(input int c0, input int c1, input bit clr_coincide);
      bit          ok;
      int          maxc;
      logic [1:0]  exp_done;
      logic [31:0] exp_time;
      logic        exp_w, exp_tie, exp_wv;
      wait_go(ok);
      if (!ok) begin
         enter = 2'b00;
         return;
      end
      maxc = (c0 > c1) ? c0 : c1;
      for (int c = 0; c <= maxc; c++) begin
         if (c == c0) enter[0] = 1'b1;
         if (c == c1) enter[1] = 1'b1;
         clear_best = clr_coincide && (c == maxc);
         @(negedge clk);
      end
      clear_best = 1'b0;
      exp_done = {c1 >= 0, c0 >= 0};
      exp_time = {(c1 >= 0) ? to_bcd4(c1 / TICK) : 16'h0, (c0 >= 0) ? to_bcd4(c0 / TICK) : 16'h0};
      exp_wv   = (c0 >= 0) || (c1 >= 0);
      exp_tie  = (c0 >= 0) && (c1 >= 0) && (c0 == c1);
      exp_w    = (c0 < 0) || ((c1 >= 0) && (c1 < c0));
      if (clr_coincide) begin
         best_ms[0] = 9999;
         best_ms[1] = 9999;
      end else begin
         if (c0 >= 0 && c0 / TICK < best_ms[0]) best_ms[0] = c0 / TICK;
         if (c1 >= 0 && c1 / TICK < best_ms[1]) best_ms[1] = c1 / TICK;
      end
      check("race_state", st, DONE);
      check("race_color", color, COL_WHITE);
      check("race_ptime", p_time, exp_time);
      check("race_done", done_mask, exp_done);
      check("race_late", late, 2'b00);
      check("race_wv", winner_valid, exp_wv);
      check("race_tie", tie, exp_tie);
      if (exp_wv) check("race_winner", winner, exp_w);
      check("race_live", live, to_bcd4((maxc + 1) / TICK));
      check("race_best", p_best, best_exp());
      enter = 2'b00;
      @(negedge clk);
   endtask

   // Two-digit core: nobody (or player 0 in the saturation cycle) presses
   task automatic timeout2(input bit press0);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 200 && st2 != GO; i++) @(negedge clk);
      check("t2_go", st2, GO);
      if (st2 != GO) return;
      for (int c = 0; c < SAT_C - 1; c++) @(negedge clk);
      check("t2_live98", live2, 8'h98);
      @(negedge clk);
      check("t2_live99", live2, 8'h99);
      check("t2_still_go", st2, GO);
      if (press0) enter2[0] = 1'b1;
      @(negedge clk);
      check("t2_state", st2, DONE);
      check("t2_late", late2, press0 ? 2'b10 : 2'b11);
      check("t2_done", done2, press0 ? 2'b01 : 2'b00);
      check("t2_ptime", p_time2, 16'h9999);
      check("t2_wv", wv2, press0);
      check("t2_winner", winner2, 1'b0);
      check("t2_best", p_best2, 16'h9999);
      repeat (8) @(negedge clk);
      check("t2_hold", live2, 8'h99);
      enter2 = 2'b00;
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, st, IDLE);
      check({tag, "_color"}, color, COL_BLUE);
      check({tag, "_live"}, live, 16'h0);
      check({tag, "_ptime"}, p_time, 32'h0);
      check({tag, "_pbest"}, p_best, 32'h9999_9999);
      check({tag, "_done"}, done_mask, 2'b00);
      check({tag, "_fs"}, false_start, 2'b00);
      check({tag, "_late"}, late, 2'b00);
      check({tag, "_winner"}, winner, 1'b0);
      check({tag, "_wv"}, winner_valid, 1'b0);
      check({tag, "_tie"}, tie, 1'b0);
   endtask

   initial begin
      bit ok;
      int c, r;
      best_ms[0] = 9999;
      best_ms[1] = 9999;
      #2 RESET = 1'b0;
      repeat (2) @(negedge clk);
      RESET = 1'b1;
      @(negedge clk);
      check_reset_values("rst");

      // Player 1 at 25 ms, player 0 at 40 ms
      start_round();
      race(40 * TICK + int'($urandom_range(0, 3)), 25 * TICK + int'($urandom_range(0, 3)), 1'b0);

      // Same-cycle presses at 12 ms
      start_round();
      c = 12 * TICK + int'($urandom_range(0, 3));
      race(c, c, 1'b0);

      // Standalone clear of best times
      clear_best = 1'b1;
      @(negedge clk);
      clear_best = 1'b0;
      best_ms[0] = 9999;
      best_ms[1] = 9999;
      check("clear_best", p_best, 32'h9999_9999);

      // 30 then 50 ms keeps the 30 ms best
      r = int'($urandom_range(0, 3));
      start_round();
      race(30 * TICK + r, 50 * TICK + r, 1'b0);
      start_round();
      race(50 * TICK + r, 30 * TICK + r, 1'b0);
      check("best_30", p_best, 32'h0030_0030);

      // clear_best coinciding with the DONE-entry update wins
      start_round();
      race(10 * TICK + r, 15 * TICK + r, 1'b1);

      // Press on a tick cycle latches the pre-increment value
      start_round();
      race(9 * TICK + (TICK - 1), 10 * TICK, 1'b0);

      // Random races
      for (int n = 0; n < 6; n++) begin
         int a, b;
         a = int'($urandom_range(0, 60 * TICK - 1));
         b = int'($urandom_range(0, 60 * TICK - 1));
         if ($urandom_range(0, 3) == 0) b = a;
         start_round();
         race(a, b, 1'b0);
      end

      // Player 0 false-starts, player 1 finishes at 7 ms
      start_round();
      @(negedge clk);
      enter[0] = 1'b1;
      @(negedge clk);
      check("fs_mask", false_start, 2'b01);
      check("fs_armed", st, ARMED);
      race(-1, 7 * TICK + int'($urandom_range(0, 3)), 1'b0);
      check("fs_keep", false_start, 2'b01);

      // Both false-start -> FAULT
      start_round();
      enter = 2'b11;
      @(negedge clk);
      check("fault_state", st, FAULT);
      check("fault_color", color, COL_MAGENTA);
      check("fault_fs", false_start, 2'b11);
      check("fault_best", p_best, best_exp());
      enter = 2'b00;
      @(negedge clk);

      // Saturation on the two-digit core
      timeout2(1'b0);
      timeout2(1'b1);

      // Reset mid-GO aborts at once
      start_round();
      wait_go(ok);
      repeat (20) @(negedge clk);
      RESET = 1'b0;
      #1;
      best_ms[0] = 9999;
      best_ms[1] = 9999;
      check_reset_values("abort");
      check("abort_best_model", p_best, best_exp());
      @(negedge clk);
      RESET = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
